// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store path: funct3 size codes, LSU FSM
// states and the access alignment rule.
package riscv_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } lsu_state_t;

   // Returns 1 when an access of the given size at the given byte offset is
   // legal. Unknown size codes (3, 6, 7) are rejected like misaligned ones.
   function automatic logic ldst_aligned(input logic [2:0] size, input logic [1:0] off);
      logic ok;
      case (size)
         LDST_B, LDST_BU: ok = 1'b1;
         LDST_H, LDST_HU: ok = ~off[0];
         LDST_W:          ok = (off == 2'b00);
         default:         ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it according to the latched funct3 size code.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  size,
   output logic [31:0] data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the byte lane and half lane addressed by the latched offset.
   always_comb begin
      byte_s = rdata[7:0];
      case (off)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = rdata[7:0];
      endcase
      if (off[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // Extend the selected lane; words pass straight through.
   always_comb begin
      data = rdata;
      case (size)
         LDST_B:  data = {{24{byte_s[7]}}, byte_s};
         LDST_BU: data = {24'd0, byte_s};
         LDST_H:  data = {{16{half_s[15]}}, half_s};
         LDST_HU: data = {16'd0, half_s};
         LDST_W:  data = rdata;
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns core memory-stage requests into word-addressed
// memory transactions with byte enables, stalls the core across the
// one-cycle registered read latency and returns extended load data.
// Misaligned or illegal-size requests are flagged and never reach memory.
module riscv_lsu
   import riscv_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 32'd1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        misalign_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   // The FSM assumes read data arrives exactly one cycle after the request.
   if (MEM_LATENCY != 32'd1) begin : g_latency_check
      $fatal(1, "riscv_lsu: only MEM_LATENCY = 1 is supported");
   end

   lsu_state_t  state_r;
   logic [1:0]  lat_off_r;
   logic [2:0]  lat_size_r;
   logic        lat_we_r;

   logic        aligned_s;
   logic        access_s;
   logic        store_s;
   logic        done_s;
   logic [31:0] ld_data_s;

   // Request qualification; reset masks every core/memory handshake output.
   always_comb begin
      aligned_s = ldst_aligned(core_size_i, core_addr_i[1:0]);
      access_s  = core_req_i & aligned_s & ~rst_i;
      store_s   = access_s & core_we_i;
      done_s    = (state_r == WAIT) & mem_ready_i;
   end

   // Handshake outputs toward core and memory.
   always_comb begin
      core_stall_o = access_s & ~done_s;
      misalign_o   = core_req_i & ~aligned_s & ~rst_i;
      mem_req_o    = access_s;
      mem_we_o     = store_s;
      mem_addr_o   = core_addr_i;
   end

   // Store packing: replicate data across lanes, enable only addressed bytes.
   always_comb begin
      mem_be_o = 4'b0000;
      mem_wd_o = core_wd_i;
      case (core_size_i)
         LDST_B, LDST_BU: begin
            mem_wd_o = {4{core_wd_i[7:0]}};
            if (store_s) begin
               mem_be_o = 4'b0001 << core_addr_i[1:0];
            end else begin
               mem_be_o = 4'b0000;
            end
         end
         LDST_H, LDST_HU: begin
            mem_wd_o = {2{core_wd_i[15:0]}};
            if (store_s) begin
               mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
            end else begin
               mem_be_o = 4'b0000;
            end
         end
         LDST_W: begin
            mem_wd_o = core_wd_i;
            if (store_s) begin
               mem_be_o = 4'b1111;
            end else begin
               mem_be_o = 4'b0000;
            end
         end
         default: begin
            mem_wd_o = core_wd_i;
            mem_be_o = 4'b0000;
         end
      endcase
   end

   lsu_load_align u_load_align (
      .rdata (mem_rd_i),
      .off   (lat_off_r),
      .size  (lat_size_r),
      .data  (ld_data_s)
   );

   // Load data is only presented in the completing cycle of a load.
   always_comb begin
      if (done_s & ~lat_we_r & ~rst_i) begin
         core_rd_o = ld_data_s;
      end else begin
         core_rd_o = 32'd0;
      end
   end

   // IDLE/WAIT sequencing and latching of the load-extraction controls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         lat_off_r  <= 2'd0;
         lat_size_r <= LDST_W;
         lat_we_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (access_s) begin
                  state_r    <= WAIT;
                  lat_off_r  <= core_addr_i[1:0];
                  lat_size_r <= core_size_i;
                  lat_we_r   <= core_we_i;
               end
            end
            WAIT: begin
               // A dropped request abandons the access rather than hanging.
               if (!core_req_i || mem_ready_i) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed testbench for riscv_lsu with a small registered-read data memory.
module tb_riscv_lsu;
   import riscv_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        misalign_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:1023];

   riscv_lsu #(.MEM_LATENCY(32'd1)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .core_req_i   (core_req_i),
      .core_we_i    (core_we_i),
      .core_size_i  (core_size_i),
      .core_addr_i  (core_addr_i),
      .core_wd_i    (core_wd_i),
      .core_rd_o    (core_rd_o),
      .core_stall_o (core_stall_o),
      .misalign_o   (misalign_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wd_o     (mem_wd_o),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_i  (mem_ready_i)
   );

   always #5 clk_i = ~clk_i;

   // Memory model: 4 KiB in range, registered read, byte-enabled writes.
   always @(posedge clk_i) begin
      if (mem_req_o) begin
         if (mem_addr_o < 32'h0000_1000) begin
            mem_rd_i <= mem[mem_addr_o[11:2]];
            if (mem_we_o) begin
               for (int b = 0; b < 4; b++) begin
                  if (mem_be_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
               end
            end
         end else begin
            mem_rd_i <= 32'hDEAD_BEEF;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one access and hold it until the stall drops. k = number of WAIT
   // cycles with mem_ready_i low. Issue-cycle outputs are returned too.
   task automatic run_access(input string tag, input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wd, input int k,
                             output logic [31:0] rd, output int stalls,
                             output logic [3:0] be0, output logic [31:0] wd0,
                             output logic we0, output logic [31:0] rd0);
      int  cyc;
      bit  done;
      cyc = 0; done = 1'b0; stalls = 0; rd = 32'd0;
      be0 = 4'd0; wd0 = 32'd0; we0 = 1'b0; rd0 = 32'd0;
      @(posedge clk_i); #1;
      core_req_i = 1'b1; core_we_i = we; core_size_i = size;
      core_addr_i = addr; core_wd_i = wd;
      while (!done && cyc < 20) begin
         mem_ready_i = (cyc >= 1 && cyc <= k) ? 1'b0 : 1'b1;
         #4;
         if (cyc == 0) begin
            be0 = mem_be_o; wd0 = mem_wd_o; we0 = mem_we_o; rd0 = core_rd_o;
         end
         if (core_stall_o) begin
            stalls++;
            @(posedge clk_i); #1;
            cyc++;
         end else begin
            rd = core_rd_o;
            done = 1'b1;
         end
      end
      if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
      core_req_i = 1'b0; core_we_i = 1'b0;
      mem_ready_i = 1'b1;
   endtask

   // Present a rejected request for two cycles and confirm it never starts.
   task automatic run_misalign(input string tag, input logic we, input logic [2:0] size,
                               input logic [31:0] addr);
      @(posedge clk_i); #1;
      core_req_i = 1'b1; core_we_i = we; core_size_i = size;
      core_addr_i = addr; core_wd_i = 32'h1234_5678;
      #4;
      check({tag, "_misalign"}, 32'(misalign_o), 32'd1);
      check({tag, "_memreq"},   32'(mem_req_o), 32'd0);
      check({tag, "_stall"},    32'(core_stall_o), 32'd0);
      @(posedge clk_i); #1; #4;
      check({tag, "_state"},    32'(dut.state_r), 32'(IDLE));
      check({tag, "_misalign2"}, 32'(misalign_o), 32'd1);
      core_req_i = 1'b0; core_we_i = 1'b0;
   endtask

   logic [31:0] rd, wd0, rd0;
   logic [3:0]  be0;
   logic        we0;
   int          stalls;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      rst_i = 1'b1; mem_ready_i = 1'b1;
      core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W;
      core_addr_i = 32'h0000_0100; core_wd_i = 32'd0;

      // Reset state with an aligned request pending.
      #3;
      check("rst_stall",    32'(core_stall_o), 32'd0);
      check("rst_memreq",   32'(mem_req_o), 32'd0);
      check("rst_rd",       core_rd_o, 32'd0);
      check("rst_lat_off",  32'(dut.lat_off_r), 32'd0);
      check("rst_lat_size", 32'(dut.lat_size_r), 32'(LDST_W));
      core_addr_i = 32'h0000_0101;
      #1;
      check("rst_misalign", 32'(misalign_o), 32'd0);
      core_req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // SB 0x102 then LW 0x100.
      run_access("sb", 1'b1, LDST_B, 32'h0000_0102, 32'h0000_00A5, 0, rd, stalls, be0, wd0, we0, rd0);
      check("sb_be",     32'(be0), 32'h0000_0004);
      check("sb_wd",     wd0, 32'hA5A5_A5A5);
      check("sb_we",     32'(we0), 32'd1);
      check("sb_stalls", 32'(stalls), 32'd1);
      run_access("lw", 1'b0, LDST_W, 32'h0000_0100, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("lw_rd",     rd, 32'h00A5_0000);
      check("lw_stalls", 32'(stalls), 32'd1);
      check("lw_be",     32'(be0), 32'd0);
      check("lw_rd0",    rd0, 32'd0);

      // Byte loads with sign/zero extension.
      run_access("sw1", 1'b1, LDST_W, 32'h0000_0100, 32'h8012_3456, 0, rd, stalls, be0, wd0, we0, rd0);
      check("sw1_be", 32'(be0), 32'h0000_000F);
      check("sw1_wd", wd0, 32'h8012_3456);
      run_access("lb", 1'b0, LDST_B, 32'h0000_0103, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("lb_rd", rd, 32'hFFFF_FF80);
      run_access("lbu", 1'b0, LDST_BU, 32'h0000_0103, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("lbu_rd", rd, 32'h0000_0080);

      // Half loads.
      run_access("sw2", 1'b1, LDST_W, 32'h0000_0200, 32'h8001_7FFF, 0, rd, stalls, be0, wd0, we0, rd0);
      run_access("lh", 1'b0, LDST_H, 32'h0000_0202, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("lh_rd", rd, 32'hFFFF_8001);
      run_access("lhu", 1'b0, LDST_HU, 32'h0000_0202, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("lhu_rd", rd, 32'h0000_8001);
      run_access("lh0", 1'b0, LDST_H, 32'h0000_0200, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("lh0_rd", rd, 32'h0000_7FFF);

      // Upper-half store packing and its effect in memory.
      run_access("sh", 1'b1, LDST_H, 32'h0000_0302, 32'h1234_BEEF, 0, rd, stalls, be0, wd0, we0, rd0);
      check("sh_be", 32'(be0), 32'h0000_000C);
      check("sh_wd", wd0, 32'hBEEF_BEEF);
      run_access("lw3", 1'b0, LDST_W, 32'h0000_0300, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("lw3_rd", rd, 32'hBEEF_0000);

      // Rejected accesses.
      run_misalign("lw5",   1'b0, LDST_W, 32'h0000_0005);
      run_misalign("sh3",   1'b1, LDST_H, 32'h0000_0003);
      run_misalign("size3", 1'b0, 3'd3,   32'h0000_0000);

      // Out-of-range load, then with mem_ready_i low for 3 WAIT cycles.
      run_access("oor", 1'b0, LDST_W, 32'h0001_0000, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("oor_rd",     rd, 32'hDEAD_BEEF);
      check("oor_stalls", 32'(stalls), 32'd1);
      run_access("slow", 1'b0, LDST_W, 32'h0001_0000, 32'd0, 3, rd, stalls, be0, wd0, we0, rd0);
      check("slow_rd",     rd, 32'hDEAD_BEEF);
      check("slow_stalls", 32'(stalls), 32'd4);

      // Reset asserted while waiting on memory.
      @(posedge clk_i); #1;
      core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W;
      core_addr_i = 32'h0000_0100; mem_ready_i = 1'b1;
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0;
      #1;
      check("mid_state_wait", 32'(dut.state_r), 32'(WAIT));
      check("mid_stall_pre",  32'(core_stall_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("mid_stall_rst", 32'(core_stall_o), 32'd0);
      check("mid_state_rst", 32'(dut.state_r), 32'(IDLE));
      check("mid_memreq",    32'(mem_req_o), 32'd0);
      core_req_i = 1'b0;
      #1;
      rst_i = 1'b0; mem_ready_i = 1'b1;
      run_access("reissue", 1'b0, LDST_W, 32'h0000_0100, 32'd0, 0, rd, stalls, be0, wd0, we0, rd0);
      check("reissue_rd",     rd, 32'h8012_3456);
      check("reissue_stalls", 32'(stalls), 32'd1);

      @(posedge clk_i); #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the core's memory-stage controls and the external data memory (`ext_mem`). Translates core load/store requests (address, funct3 size code, write data) into word-addressed memory transactions with byte enables and lane-replicated write data. Holds the core stalled for the memory's one-cycle registered read latency, then returns sign- or zero-extended load data. Detects misaligned accesses and suppresses them.

## Interface
Parameters:
- `MEM_LATENCY`, 1: cycles from request to valid `mem_rd_i`. Only value 1 is supported.

Ports:
- `clk_i`  in  1  clock; reset is asynchronous and active-high.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `core_req_i`  in  1  core requests a memory access this cycle.
- `core_we_i`  in  1  1 = store, 0 = load.
- `core_size_i`  in  3  funct3: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- `core_addr_i`  in  32  byte address.
- `core_wd_i`  in  32  store data, right-aligned.
- `core_rd_o`  out  32  extended load data.
- `core_stall_o`  out  1  core must hold its pipeline and inputs.
- `misalign_o`  out  1  one-cycle flag: access rejected.
- `mem_req_o`, `mem_we_o`  out  1 each  to `ext_mem`.
- `mem_be_o`  out  4  byte enables.
- `mem_addr_o`  out  32  = `core_addr_i`; the memory ignores bits [1:0].
- `mem_wd_o`  out  32  lane-replicated store data.
- `mem_rd_i`  in  32  memory read data.
- `mem_ready_i`  in  1  memory ready.

## Operation
- FSM states: IDLE and WAIT. Reset state is IDLE.
- IDLE: if `core_req_i` is set and the access is aligned, go to WAIT. Capture `core_addr_i[1:0]` and `core_size_i` into `lat_off` and `lat_size`.
- WAIT: if `mem_ready_i` is set, go to IDLE; otherwise stay in WAIT.
- `core_stall_o` = `core_req_i` and the access is aligned and NOT (state == WAIT and `mem_ready_i`).
- `mem_req_o` = `core_req_i` and the access is aligned, in both states.
- `mem_we_o` = `core_we_i` and `mem_req_o`.
- Alignment:
  - H/HU is misaligned if `addr[0]` = 1.
  - W is misaligned if `addr[1:0]` ≠ 0.
  - Size codes 3, 6, 7 are illegal and are treated as misaligned.
  - A misaligned request gives `misalign_o` = 1 in the same cycle (combinational), `mem_req_o` = 0, no stall, and the FSM stays in IDLE.
- Byte enables, stores only (`mem_be_o` = 0 when not storing):
  - B: `4'b0001 << addr[1:0]`.
  - H: `addr[1]` ? `1100` : `0011`.
  - W: `1111`.
- Store data:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd`.
- Load extraction uses `lat_off` and `lat_size`:
  - Byte = `mem_rd_i[8*off +: 8]`.
  - Half = `mem_rd_i[16*off[1] +: 16]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- `core_rd_o` is valid only in the cycle WAIT and `mem_ready_i` with a load. It is 0 otherwise.
- Reset mid-access: the FSM returns to IDLE immediately and `core_stall_o` drops. The core must re-issue the access.
- `core_req_i` dropping in WAIT (not allowed by protocol) forces the FSM back to IDLE on the next edge.

## Timing
- Every aligned access takes 2 cycles: issue in cycle N (stall = 1), complete in cycle N+1 (stall = 0, `core_rd_o` valid).
- A store writes at the edge ending cycle N. Holding `mem_req_o`/`mem_we_o` through N+1 rewrites the same value, which is harmless.
- Back-to-back accesses: the next request is seen in IDLE in cycle N+2.
- `mem_ready_i` = 0 in WAIT extends the stall one cycle per cycle it stays 0.
- Outputs during reset:
  - `core_stall_o` = 0, `mem_req_o` = 0, `misalign_o` = 0, `core_rd_o` = 0.
  - `lat_off` = 0 and `lat_size` = 2 (W).
- No combinational path from `mem_rd_i` to any memory-side output.

## Structure
- Shared package `riscv_pkg` holds:
  - `LDST_B`/`LDST_H`/`LDST_W`/`LDST_BU`/`LDST_HU` constants.
  - An `lsu_state_t` enum {IDLE, WAIT}.
- Sub-module `lsu_load_align` holds the combinational byte/half extraction and extension. The FSM, alignment check and store packing stay in `riscv_lsu`.

## Test plan
- SB, `addr` = 0x102, `wd` = 0x0000_00A5 → `mem_be_o` = 0100, `mem_wd_o` = 0xA5A5_A5A5, stall 1 cycle. A later LW from 0x100 returns 0x00A5_0000 (memory zeroed first).
- LB and LBU at 0x103 with word 0x8012_3456 stored at 0x100 → LB returns 0xFFFF_FF80, LBU returns 0x0000_0080.
- LH and LHU at 0x202 with word 0x8001_7FFF → LH returns 0xFFFF_8001, LHU returns 0x0000_8001. LH at 0x200 returns 0x0000_7FFF.
- LW at 0x5, SH at 0x3, size code 3 at 0x0 → `misalign_o` = 1 in the same cycle, `mem_req_o` = 0, `core_stall_o` = 0, FSM stays in IDLE.
- LW at 0x1_0000 (out of range) → `core_rd_o` = 0xDEAD_BEEF after a 1-cycle stall. `mem_ready_i` forced to 0 for 3 cycles in WAIT → stall lasts 4 cycles.
- Assert `rst_i` in WAIT → stall drops asynchronously and the FSM is in IDLE. Re-issuing the same LW completes in 2 cycles.
